// File: rtl/cdb_arbiter_if.sv
// Bundles the per-FU result handshakes and the broadcast bus of cdb_arbiter.
// The master side drives FU results; the slave side is the arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_FU   = 4,
  parameter int unsigned ROB_ID_W = 5
);
  logic [NUM_FU-1:0]               fu_valid;
  logic [NUM_FU-1:0]               fu_ready;
  logic [NUM_FU-1:0][ROB_ID_W-1:0] fu_rob_id;
  logic [NUM_FU-1:0][4:0]          fu_rd_addr;
  logic [NUM_FU-1:0][31:0]         fu_data;

  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [4:0]          cdb_rd_addr;
  logic [31:0]         cdb_data;

  modport master (
    output fu_valid, fu_rob_id, fu_rd_addr, fu_data,
    input  fu_ready, cdb_valid, cdb_rob_id, cdb_rd_addr, cdb_data
  );

  modport slave (
    input  fu_valid, fu_rob_id, fu_rd_addr, fu_data,
    output fu_ready, cdb_valid, cdb_rob_id, cdb_rd_addr, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small FIFO per functional unit, round-robin grant,
// one registered broadcast per cycle.
module cdb_arbiter #(
  parameter int unsigned NUM_FU   = 4,
  parameter int unsigned ROB_ID_W = 5,
  parameter int unsigned Q_DEPTH  = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(Q_DEPTH + 1);
  localparam int unsigned RrW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [4:0]          rd_addr;
    logic [31:0]         data;
  } entry_t;

  entry_t          mem_q    [NUM_FU][Q_DEPTH];
  logic [PtrW-1:0] rd_ptr_q [NUM_FU];
  logic [PtrW-1:0] rd_ptr_d [NUM_FU];
  logic [PtrW-1:0] wr_ptr_q [NUM_FU];
  logic [PtrW-1:0] wr_ptr_d [NUM_FU];
  logic [CntW-1:0] count_q  [NUM_FU];
  logic [CntW-1:0] count_d  [NUM_FU];

  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;

  logic [RrW-1:0] rr_ptr_q;
  logic [RrW-1:0] rr_ptr_d;
  logic [RrW-1:0] gnt_idx;
  logic           gnt_valid;

  logic   cdb_valid_q;
  logic   cdb_valid_d;
  entry_t cdb_q;
  entry_t cdb_d;

  // Ready and grant eligibility come from registered occupancy only, so a full
  // queue stays not-ready even in the cycle it is being dequeued.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      ready[i]    = count_q[i] != CntW'(Q_DEPTH);
      nonempty[i] = count_q[i] != '0;
    end
  end

  assign bus.fu_ready = ready;

  // Round-robin search starting at rr_ptr_q; first non-empty queue wins.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_FU;
      if (!gnt_valid && nonempty[cand[RrW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[RrW-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_d       = cdb_q;
    push        = '0;
    pop         = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      push[i]     = bus.fu_valid[i] && ready[i] && !flush;
      pop[i]      = gnt_valid && !flush && (gnt_idx == RrW'(i));
      wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(pop[i]);
      count_d[i]  = count_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
      end
    end
    if (flush) begin
      rr_ptr_d = '0;
    end else if (gnt_valid) begin
      rr_ptr_d    = RrW'((32'(gnt_idx) + 1) % NUM_FU);
      cdb_valid_d = 1'b1;
      cdb_d       = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (push[i] && !rst) begin
        mem_q[i][wr_ptr_q[i]] <= '{rob_id:  bus.fu_rob_id[i],
                                   rd_addr: bus.fu_rd_addr[i],
                                   data:    bus.fu_data[i]};
      end
    end
  end

  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_rob_id  = cdb_q.rob_id;
  assign bus.cdb_rd_addr = cdb_q.rd_addr;
  assign bus.cdb_data    = cdb_q.data;

endmodule
